// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants: check modes, stored entry layout
// and the saturating error-counter helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int ERR_CNT_W   = 8;

    typedef enum logic [2:0] {
        CHK_NONE = 3'd0,
        CHK_EVEN = 3'd1,
        CHK_ODD  = 3'd2,
        CHK_ZERO = 3'd3,
        CHK_ONE  = 3'd4
    } chk_mode_e;

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } entry_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and level,
    // so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular store of {err,data}, show-ahead pop.
// Build option: define UART_RX_FIFO_ERR_DROP_EN to discard error bytes instead of storing them.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW:0]          level,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

    logic                 r_in_ready;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;
    logic                 r_overflow;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic              w_push_hs;
    logic              w_store_req;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [DATA_W:0]   w_wr_entry;
    logic [DATA_W:0]   w_rd_entry;

    assign w_push_hs = in_valid & r_in_ready;
    assign w_full    = (r_level == LVL_FULL);
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid & out_ready;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    assign w_store_req = w_push_hs & ~in_err;
    assign w_wr_entry  = {1'b0, in_data};
    assign out_err     = 1'b0;
`else
    assign w_store_req = w_push_hs;
    assign w_wr_entry  = {in_err, in_data};
    assign out_err     = out_valid & w_rd_entry[DATA_W];
`endif

    // A pop on the same edge frees the slot, so a full buffer can still accept.
    assign w_wr_en = w_store_req & (~w_full | w_pop) & ~clr;
    assign w_drop  = w_store_req & w_full & ~w_pop;

    uart_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_in_ready <= 1'b1;
            if (clr) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_level    <= '0;
                r_overflow <= 1'b0;
                r_err_cnt  <= '0;
            end else begin
                if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_wr_en, w_pop})
                    2'b10:   r_level <= r_level + (AW+1)'(1);
                    2'b01:   r_level <= r_level - (AW+1)'(1);
                    default: r_level <= r_level;
                endcase
                if (w_drop) r_overflow <= 1'b1;
                if (w_push_hs && in_err) r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign in_ready = r_in_ready;
    assign out_data = out_valid ? w_rd_entry[DATA_W-1:0] : '0;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DATA_W=8, DEPTH=16); honours UART_RX_FIFO_ERR_DROP_EN.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [7:0] in_data;
    logic       in_err;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_err    (in_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic e,
                        input logic r, input logic c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_err    = e;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_data = '0; in_err = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_post", in_ready, 1);

        // Basic push/pop, latency 1
        step(1, 8'h55, 0, 0, 0);
        check("b_valid1", out_valid, 1);
        check("b_data1", out_data, 8'h55);
        step(1, 8'hA3, 0, 0, 0);
        check("b_level2", level, 2);
        step(0, 8'h00, 0, 1, 0);
        check("b_data2", out_data, 8'hA3);
        check("b_level1", level, 1);
        step(0, 8'h00, 0, 1, 0);
        check("b_valid0", out_valid, 0);
        check("b_level0", level, 0);
        step(0, 8'h00, 0, 1, 0);
        check("b_pop_empty_lvl", level, 0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        check("f_level16", level, 16);
        check("f_head", out_data, 8'h00);
        check("f_ovf0", overflow, 0);
        step(1, 8'h10, 0, 0, 0);
        check("f_drop_ovf", overflow, 1);
        check("f_drop_level", level, 16);

        // Push with concurrent pop while full: no drop
        step(1, 8'h77, 0, 1, 0);
        check("fp_level", level, 16);
        check("fp_ovf", overflow, 1);
        check("fp_head", out_data, 8'h01);
        for (int i = 1; i < 16; i++) begin
            check("fp_order", out_data, 32'(i));
            step(0, 8'h00, 0, 1, 0);
        end
        check("fp_last", out_data, 8'h77);
        step(0, 8'h00, 0, 1, 0);
        check("fp_empty", out_valid, 0);

        // Wrap-around streaming with level <= 3
        for (int i = 0; i < 40; i++) begin
            if (i >= 3) check("w_order", out_data, 32'(8'h80 + i - 3));
            step(1, 8'(8'h80 + i), 0, (i >= 3), 0);
            check("w_level_max", (level <= 3), 1);
        end
        for (int i = 37; i < 40; i++) begin
            check("w_tail", out_data, 32'(8'h80 + i));
            step(0, 8'h00, 0, 1, 0);
        end
        check("w_empty", level, 0);

        // clr clears overflow (still set from the fill test)
        step(0, 8'h00, 0, 0, 1);
        check("c_ovf_clr", overflow, 0);

        // Error path
        step(1, 8'h41, 1, 0, 0);
        step(1, 8'h42, 0, 0, 0);
        check("e_cnt1", err_cnt, 1);
`ifdef UART_RX_FIFO_ERR_DROP_EN
        check("e_level", level, 1);
        check("e_data", out_data, 8'h42);
        check("e_flag", out_err, 0);
        step(0, 8'h00, 0, 1, 0);
`else
        check("e_level", level, 2);
        check("e_data1", out_data, 8'h41);
        check("e_flag1", out_err, 1);
        step(0, 8'h00, 0, 1, 0);
        check("e_data2", out_data, 8'h42);
        check("e_flag2", out_err, 0);
        step(0, 8'h00, 0, 1, 0);
`endif
        check("e_empty", out_valid, 0);
        for (int i = 0; i < 300; i++) step(1, 8'hEE, 1, 0, 0);
        check("e_sat", err_cnt, 255);

        // clr with level 5 and a concurrent push
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        check("c_level5", level, 5);
        step(1, 8'h99, 1, 1, 1);
        check("c_level", level, 0);
        check("c_ovf", overflow, 0);
        check("c_errcnt", err_cnt, 0);
        check("c_valid", out_valid, 0);
        check("c_in_ready", in_ready, 1);
        step(0, 8'h00, 0, 0, 0);
        check("c_valid_next", out_valid, 0);

        // Async reset mid-stream
        step(1, 8'h61, 1, 0, 0);
        step(1, 8'h62, 0, 0, 0);
        check("a_level_pre", level, 2);
        check("a_err_pre", err_cnt, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("a_in_ready", in_ready, 0);
        check("a_level", level, 0);
        check("a_valid", out_valid, 0);
        check("a_data", out_data, 0);
        check("a_err", out_err, 0);
        check("a_errcnt", err_cnt, 0);
        check("a_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
